e_mdu: RTL
==========

Name: e_mdu

Overview:
- Multiply/divide unit for the E stage of the 5-stage pipeline.
- Owns the HI/LO registers and sequences mult/multu/div/divu over a fixed multi-cycle latency.
- Raises busy, plus a D-stage stall request, so the hazard unit can hold later md-class instructions.
- Serves mfhi/mflo reads and mthi/mtlo writes.

Parameters:
- MULT_CYCLES, 5, cycles busy is high for mult/multu (and madd/maddu when enabled); legal range 1-15.
- DIV_CYCLES, 10, cycles busy is high for div/divu; legal range 1-15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle launch pulse, valid with mdu_op in 1-4 (9-10 when enabled).
- mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu.
- rs_data  input  32  forwarded rs operand (E stage).
- rt_data  input  32  forwarded rt operand (E stage).
- md_in_d  input  1  instruction in D is md-class (ops 1-10).
- busy  output  1  operation in flight.
- stall_md  output  1  = md_in_d & (start | busy).
- hi  output  32  HI register.
- lo  output  32  LO register.
- mdu_out  output  32  mfhi → hi, mflo → lo, else 0 (combinational).

Behaviour:
- Reset (clk edge with reset=1): state IDLE, counter 0, HI=LO=0, pending results 0, busy=0. Applies mid-operation: the in-flight result is discarded.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Launch:
  - Condition: IDLE, start=1 and mdu_op is a launch op.
  - Edge ending cycle T: compute the result into pending registers.
  - Counter loads MULT_CYCLES or DIV_CYCLES; state goes to RUN.
- Arithmetic:
  - mult: signed 32x32 → 64; pend_hi = product[63:32], pend_lo = product[31:0].
  - multu: same, unsigned.
  - div: pend_lo = quotient, pend_hi = remainder; truncate toward zero, remainder takes the dividend's sign.
  - divu: unsigned quotient/remainder.
  - Division by zero: pending results equal the current HI/LO, so commit leaves HI/LO unchanged. No trap.
  - div with 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Run timing:
  - busy is high in cycles T+1 .. T+N (N = selected latency).
  - Counter decrements each edge; on the edge where counter==1, HI/LO ← pending and state → IDLE.
  - New HI/LO is visible in cycle T+N+1.
- start while RUN: ignored; there is no restart and no queueing. The hazard unit must prevent this case, and the bench checks that it is ignored.
- start with a non-launch op: ignored.
- mthi/mtlo: write HI/LO from rs_data at the edge, only when IDLE and start=0. Ignored while RUN.
- mfhi/mflo: combinational read of the current HI/LO. Callers stall on stall_md, so no read is issued during RUN.
- Same-cycle launch and mthi: impossible, since one op is present per cycle.
- stall_md is combinational and is high in the launch cycle T as well as T+1..T+N.

Optional Feature:
- MDU_MADD_EN defined:
  - ops 9 (madd, signed) and 10 (maddu, unsigned) are launch ops with MULT_CYCLES latency.
  - pending {hi,lo} = {HI,LO} + product, modulo 2^64, computed at launch from the HI/LO values in cycle T.
- MDU_MADD_EN undefined:
  - ops 9-10 behave as op 0: no launch, busy stays 0, mdu_out = 0.

Test Plan:
- Reset, then idle → hi=lo=0, busy=0, stall_md=0, mdu_out=0.
- mult, rs=0xFFFFFFFE (-2), rt=3, start at T → busy in T+1..T+5; HI=0xFFFFFFFF, LO=0xFFFFFFFA at T+6. multu with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- div, rs=0xFFFFFFF9 (-7), rt=2 → busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 → HI/LO unchanged after 10 busy cycles.
- mthi rs=0x12345678, then mfhi → mdu_out=0x12345678. mtlo issued during RUN → LO is not written; then mflo after completion returns the commit value.
- During RUN: md_in_d=1 → stall_md=1 every cycle; a second start at T+2 is ignored (busy drops after exactly T+5). reset at T+3 → busy=0 and hi=lo=0 on the next cycle.
- MDU_MADD_EN: with HI=0, LO=0xFFFFFFFF, maddu rs=1, rt=1 → HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus → busy stays 0 and HI/LO are unchanged.

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: E-stage multiply/divide unit.
// Holds the HI/LO registers and runs mult/multu/div/divu with a fixed latency.
// The result is computed at launch into pending registers. It is committed to
// HI/LO on the last busy cycle.
// Optional macro MDU_MADD_EN adds madd/maddu (ops 9/10), which accumulate into HI/LO.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;

  logic [0:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic        is_mul_op, is_div_op, launch;
  logic signed [63:0] a_s, b_s, prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic signed [31:0] sdiv_a, sdiv_b, squot, srem;
  logic [31:0]        udiv_b, uquot, urem;
  logic [63:0]        res;

  // Decode which ops launch a multi-cycle operation.
  always_comb begin
    is_mul_op = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
`ifdef MDU_MADD_EN
    is_mul_op = is_mul_op || (mdu_op == OP_MADD) || (mdu_op == OP_MADDU);
`endif
    is_div_op = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
    launch    = (state_q == S_IDLE) && start && (is_mul_op || is_div_op);
  end

  // Arithmetic. The divisor is forced to 1 on divide-by-zero (that result is
  // discarded) and on 0x80000000 / -1, where dividing by 1 gives the required
  // quotient 0x80000000 and remainder 0 without overflow.
  always_comb begin
    a_s      = {{32{rs_data[31]}}, rs_data};
    b_s      = {{32{rt_data[31]}}, rt_data};
    prod_s   = a_s * b_s;
    prod_u   = {32'd0, rs_data} * {32'd0, rt_data};
    div_zero = (rt_data == 32'd0);
    sdiv_a   = rs_data;
    sdiv_b   = (div_zero || (rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF))
               ? 32'sd1 : rt_data;
    squot    = sdiv_a / sdiv_b;
    srem     = sdiv_a % sdiv_b;
    udiv_b   = div_zero ? 32'd1 : rt_data;
    uquot    = rs_data / udiv_b;
    urem     = rs_data % udiv_b;
  end

  // Select the {hi,lo} result that the launching op will commit.
  always_comb begin
    res = {hi_q, lo_q};
    case (mdu_op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   res = div_zero ? {hi_q, lo_q} : {srem, squot};
      OP_DIVU:  res = div_zero ? {hi_q, lo_q} : {urem, uquot};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi_q, lo_q} + prod_s;
      OP_MADDU: res = {hi_q, lo_q} + prod_u;
`endif
      default:  res = {hi_q, lo_q};
    endcase
  end

  // Next-state logic: launch, countdown and commit, and mthi/mtlo writes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      S_IDLE: begin
        if (launch) begin
          pend_hi_d = res[63:32];
          pend_lo_d = res[31:0];
          cnt_d     = is_mul_op ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
          state_d   = S_RUN;
        end else if (!start && mdu_op == OP_MTHI) begin
          hi_d = rs_data;
        end else if (!start && mdu_op == OP_MTLO) begin
          lo_d = rs_data;
        end
      end
      default: begin
        if (cnt_q == 4'd1) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = 4'd0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
    endcase
  end

  // State registers. Reset also clears HI/LO and drops any in-flight result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  // Outputs: busy/stall to the hazard unit and the mfhi/mflo read port.
  always_comb begin
    busy     = (state_q == S_RUN);
    stall_md = md_in_d & (start | busy);
    hi       = hi_q;
    lo       = lo_q;
    case (mdu_op)
      OP_MFHI: mdu_out = hi_q;
      OP_MFLO: mdu_out = lo_q;
      default: mdu_out = 32'd0;
    endcase
  end

endmodule
